// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
//
// Round-robin arbiter that shares one 4:1 data mux between four requesters
// A..D. A grant is held until its owner drops the request, so a transfer is
// never split. The next owner is chosen on the release edge, so a busy bus
// hands over from one owner to the next without an idle cycle.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   defined   - an owner is re-arbitrated after MAX_HOLD consecutive grant
//               cycles. Another requester preempts it. If nobody else is
//               requesting, the same owner is re-granted with no gap.
//   undefined - an owner holds as long as its request stays high, and
//               MAX_HOLD is ignored.
//
// Parameters:
//   DATA_W   - width of each data lane and of y
//   MAX_HOLD - max consecutive grant cycles per owner (1..255), timeout only
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high
//   req  - request lines, bit0=A .. bit3=D
//   a..d - lane 0..3 data
//   gnt  - registered one-hot grant, 0 when idle
//   sel  - registered select of the current owner (00=a .. 11=d)
//   busy - registered, 1 while a grant is held
//   y    - selected lane while busy, else 0 (combinational)
// -----------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int unsigned DATA_W   = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic              busy,
    output logic [DATA_W-1:0] y
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_check
        $error("rr_mux_arbiter: MAX_HOLD must be in 1..255");
    end

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_gnt;
    logic [3:0]  w_gnt_next;
    logic [1:0]  r_sel;
    logic [1:0]  w_sel_next;
    logic        r_busy;
    logic        w_busy_next;
    logic [1:0]  r_ptr;
    logic [1:0]  w_ptr_next;

    logic [1:0]  w_arb_ptr;
    logic        w_found;
    logic [1:0]  w_win;
    logic        w_rearb;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]  r_hold;
    logic [7:0]  w_hold_next;
    logic        w_timeout;

    assign w_timeout = (r_state == StGrant) && (r_hold == 8'(MAX_HOLD - 1));
`endif

    // While granted, the arbiter only matters on a release or timeout edge, and
    // both of those re-arbitrate with the pointer set to the current owner.
    // Using r_sel directly lets one arbiter serve both states.
    assign w_arb_ptr = (r_state == StGrant) ? r_sel : r_ptr;

    // Scan from ptr+1 upward with wrap; descending loop so the nearest lane
    // overwrites farther ones and wins.
    always_comb begin
        logic [1:0] cand;
        w_found = 1'b0;
        w_win   = 2'b00;
        cand    = 2'b00;
        for (int i = 4; i >= 1; i--) begin
            cand = w_arb_ptr + 2'(i);
            if (req[cand]) begin
                w_found = 1'b1;
                w_win   = cand;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_sel_next   = r_sel;
        w_busy_next  = r_busy;
        w_ptr_next   = r_ptr;
        w_rearb      = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_rearb = 1'b1;
                end
            end
            StGrant: begin
                if (!req[r_sel]) begin
                    w_ptr_next = r_sel;
                    if (w_found) begin
                        w_rearb = 1'b1;
                    end else begin
                        w_state_next = StIdle;
                        w_gnt_next   = 4'b0000;
                        w_busy_next  = 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                end else if (w_timeout) begin
                    // Owner still requests, so w_found is set; it wins only
                    // when no other lane is pending.
                    w_ptr_next = r_sel;
                    w_rearb    = 1'b1;
`endif
                end
            end
            default: begin
                w_state_next = StIdle;
                w_gnt_next   = 4'b0000;
                w_busy_next  = 1'b0;
            end
        endcase

        if (w_rearb) begin
            w_state_next = StGrant;
            w_gnt_next   = 4'b0001 << w_win;
            w_sel_next   = w_win;
            w_busy_next  = 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Clears on every grant (including a re-grant), counts while granted.
    always_comb begin
        w_hold_next = 8'd0;
        if (!w_rearb && (r_state == StGrant) && (w_state_next == StGrant)) begin
            w_hold_next = r_hold + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= 8'd0;
        end else begin
            r_hold <= w_hold_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'b00;
            r_busy  <= 1'b0;
            r_ptr   <= 2'b11;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_sel   <= w_sel_next;
            r_busy  <= w_busy_next;
            r_ptr   <= w_ptr_next;
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;

    always_comb begin
        y = '0;
        if (r_busy) begin
            case (r_sel)
                2'b00:   y = a;
                2'b01:   y = b;
                2'b10:   y = c;
                default: y = d;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arbiter
//
// Directed self-checking bench for rr_mux_arbiter with DATA_W=8, MAX_HOLD=4.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_rr_mux_arbiter;

    localparam int unsigned DataW   = 8;
    localparam int unsigned MaxHold = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic [DataW-1:0] a;
    logic [DataW-1:0] b;
    logic [DataW-1:0] c;
    logic [DataW-1:0] d;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             busy;
    logic [DataW-1:0] y;

    int n_checks;
    int n_errors;

    rr_mux_arbiter #(
        .DATA_W   (DataW),
        .MAX_HOLD (MaxHold)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy),
        .y    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".gnt"}, 32'(gnt), 32'h0);
        check_eq({tag, ".busy"}, 32'(busy), 32'h0);
        check_eq({tag, ".y"}, 32'(y), 32'h0);
    endtask

    task automatic check_owner(input string tag, input int k);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        check_eq({tag, ".gnt"}, 32'(gnt), 32'(oh));
        check_eq({tag, ".sel"}, 32'(sel), 32'(k));
        check_eq({tag, ".busy"}, 32'(busy), 32'h1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        req = 4'b1111;
        a   = 8'h11;
        b   = 8'h22;
        c   = 8'h33;
        d   = 8'h44;

        // Reset held two cycles with all lanes requesting.
        step();
        step();
        check_idle("reset");
        check_eq("reset.sel", 32'(sel), 32'h0);

        // First grant after reset goes to A.
        rst = 1'b0;
        step();
        check_owner("first", 0);
        check_eq("first.y", 32'(y), 32'h11);

        // Release to idle.
        req = 4'b0000;
        step();
        check_idle("idle");

        // One-cycle latency, y follows c combinationally.
        req = 4'b0100;
        check_eq("lat.pre", 32'(gnt), 32'h0);
        step();
        check_owner("lat", 2);
        check_eq("lat.y0", 32'(y), 32'h33);
        c = 8'h01;
        #1;
        check_eq("lat.y1", 32'(y), 32'h01);
        c = 8'h00;
        #1;
        check_eq("lat.y2", 32'(y), 32'h00);
        c = 8'h5a;
        #1;
        check_eq("lat.y3", 32'(y), 32'h5a);
        req = 4'b0000;
        step();
        check_idle("lat.rel");

        // Round robin with every lane requesting: A,B,C,D,A, no bubble.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        step();
        for (int k = 0; k < 4; k++) begin
            check_owner($sformatf("rr%0d.c1", k), k);
            step();
            check_owner($sformatf("rr%0d.c2", k), k);
            step();
            check_owner($sformatf("rr%0d.c3", k), k);
            req = 4'b1111 & ~(4'b0001 << k);
            step();
            check_owner($sformatf("rr%0d.next", k), (k + 1) % 4);
            req = 4'b1111;
        end
        check_eq("rr.y", 32'(y), 32'h11);

        // B owns the bus; other lanes pile up behind it.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0010;
        step();
        check_owner("hold.start", 1);
`ifndef ARB_TIMEOUT_EN
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq($sformatf("hold.c%0d", i), 32'(gnt), 32'h2);
        end
`endif
        // B releases -> C, C releases -> D.
        req = 4'b1101;
        step();
        check_owner("hold.c", 2);
        req = 4'b1001;
        step();
        check_owner("hold.d", 3);
        check_eq("hold.d.y", 32'(y), 32'h44);

        // Mid-grant reset: pointer returns to D, so A wins next.
        rst = 1'b1;
        step();
        check_idle("midrst");
        check_eq("midrst.sel", 32'(sel), 32'h0);
        rst = 1'b0;
        step();
        check_owner("midrst.next", 0);

`ifdef ARB_TIMEOUT_EN
        // A and C alternate, four cycles each.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0101;
        step();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                check_owner($sformatf("tmo.r%0d.c%0d", r, i), (r % 2) * 2);
                step();
            end
        end
        check_owner("tmo.wrap", 0);

        // Lone requester is re-granted with no gap.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0001;
        step();
        for (int i = 0; i < 10; i++) begin
            check_owner($sformatf("tmo.solo%0d", i), 0);
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
